// File: rtl/cxl_pkg.sv
// Shared types for the cancel-order feeder: request record, FSM states and
// the saturating add used when same-client requests are merged.
package cxl_pkg;
  localparam int CLIENT_W = 5;
  localparam int AMOUNT_W = 16;

  typedef struct packed {
    logic [CLIENT_W-1:0] client_id;
    logic [AMOUNT_W-1:0] amount;
  } cxl_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } feeder_state_t;

  function automatic logic [AMOUNT_W-1:0] sat_add(input logic [AMOUNT_W-1:0] a,
                                                 input logic [AMOUNT_W-1:0] b);
    logic [AMOUNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[AMOUNT_W] ? {AMOUNT_W{1'b1}} : sum[AMOUNT_W-1:0];
  endfunction
endpackage

// File: rtl/cxl_req_fifo.sv
// Synchronous request FIFO with head read and, when CXL_FEEDER_COALESCE_EN is
// defined, a tail read plus tail amount write-back for merging.
module cxl_req_fifo
  import cxl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  cxl_req_t               push_data,
  input  logic                   pop,
  output cxl_req_t               head,
`ifdef CXL_FEEDER_COALESCE_EN
  output cxl_req_t               tail,
  input  logic                   tail_wr,
  input  logic [AMOUNT_W-1:0]    tail_amount,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  cxl_req_t      mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
`ifdef CXL_FEEDER_COALESCE_EN
    if (tail_wr) mem[wr_ptr - 1'b1].amount <= tail_amount;
`endif
  end

  assign head = mem[rd_ptr];
  assign full = (count == (AW+1)'(DEPTH));
`ifdef CXL_FEEDER_COALESCE_EN
  assign tail = mem[wr_ptr - 1'b1];
`endif
endmodule

// File: rtl/cxl_order_feeder.sv
// Feeds queued cancel requests to the accumulator, spacing same-client updates
// by GAP_CYCLES idle cycles. Optional merging: CXL_FEEDER_COALESCE_EN.
module cxl_order_feeder #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int CLIENT_W   = 5,
  parameter int AMOUNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   HRESETn,
  input  logic                   in_valid,
  input  logic [CLIENT_W-1:0]    in_client_id,
  input  logic [AMOUNT_W-1:0]    in_amount,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [CLIENT_W-1:0]    client_id,
  output logic [AMOUNT_W-1:0]    amount,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow_sticky
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);

  // Handshake: a beat moves on either side only in a cycle where valid and
  // ready are both high; a presented output is held until out_ready.
  cxl_pkg::feeder_state_t state_q, state_d;
  cxl_pkg::cxl_req_t      head, push_data;
  logic                   out_valid_q, out_valid_d;
  logic [CLIENT_W-1:0]    id_q, id_d, last_q, last_d;
  logic [AMOUNT_W-1:0]    amt_q, amt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   pop, push, fifo_push, full;

  assign push_data = '{client_id: in_client_id, amount: in_amount};
  assign push      = in_valid && in_ready;

`ifdef CXL_FEEDER_COALESCE_EN
  cxl_pkg::cxl_req_t tail;
  logic              tail_hit, merge;
  assign tail_hit = (fifo_count != '0) && (tail.client_id == in_client_id);
  assign in_ready = !full || tail_hit;
  // A lone entry being popped this cycle is no longer a merge target.
  assign merge     = push && tail_hit && !(pop && fifo_count == 1);
  assign fifo_push = push && !merge;
`else
  assign in_ready  = !full;
  assign fifo_push = push;
`endif

  cxl_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (HRESETn),
    .push       (fifo_push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
`ifdef CXL_FEEDER_COALESCE_EN
    .tail       (tail),
    .tail_wr    (merge),
    .tail_amount(cxl_pkg::sat_add(tail.amount, in_amount)),
`endif
    .count      (fifo_count),
    .full       (full)
  );

  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      state_q         <= cxl_pkg::IDLE;
      out_valid_q     <= 1'b0;
      id_q            <= '0;
      amt_q           <= '0;
      last_q          <= '0;
      gap_q           <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      id_q        <= id_d;
      amt_q       <= amt_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      if (in_valid && !in_ready) overflow_sticky <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    id_d        = id_q;
    amt_d       = amt_q;
    last_d      = last_q;
    gap_d       = gap_q;
    pop         = 1'b0;
    case (state_q)
      cxl_pkg::IDLE: begin
        if (fifo_count != '0) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          id_d        = head.client_id;
          amt_d       = head.amount;
          state_d     = cxl_pkg::ISSUE;
        end
      end
      cxl_pkg::ISSUE: begin
        if (out_ready) begin
          last_d = id_q;
          if (fifo_count == '0) begin
            out_valid_d = 1'b0;
            id_d        = '0;
            amt_d       = '0;
            state_d     = cxl_pkg::IDLE;
          end else if (GAP_CYCLES > 0 && head.client_id == last_d) begin
            out_valid_d = 1'b0;
            id_d        = '0;
            amt_d       = '0;
            gap_d       = GAP_INIT;
            state_d     = cxl_pkg::GAP;
          end else begin
            pop   = 1'b1;
            id_d  = head.client_id;
            amt_d = head.amount;
          end
        end
      end
      cxl_pkg::GAP: begin
        gap_d = gap_q - 1'b1;
        // The queue cannot drain while waiting, so the head is still valid here.
        if (gap_q == GAP_W'(1)) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          id_d        = head.client_id;
          amt_d       = head.amount;
          state_d     = cxl_pkg::ISSUE;
        end
      end
      default: state_d = cxl_pkg::IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign client_id = id_q;
  assign amount    = amt_q;
endmodule

// File: tb/tb_cxl_order_feeder.sv
// Directed bench for cxl_order_feeder: reset, latency, back-to-back, gap,
// overflow, merge (or no-merge) and mid-transfer reset scenarios.
module tb_cxl_order_feeder;
  logic        clk = 1'b0;
  logic        HRESETn = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_client_id = '0;
  logic [15:0] in_amount = '0;
  logic        in_ready;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  client_id;
  logic [15:0] amount;
  logic [3:0]  fifo_count;
  logic        overflow_sticky;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cxl_order_feeder #(.DEPTH(8), .GAP_CYCLES(2), .CLIENT_W(5), .AMOUNT_W(16)) dut (
    .clk            (clk),
    .HRESETn        (HRESETn),
    .in_valid       (in_valid),
    .in_client_id   (in_client_id),
    .in_amount      (in_amount),
    .in_ready       (in_ready),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .client_id      (client_id),
    .amount         (amount),
    .fifo_count     (fifo_count),
    .overflow_sticky(overflow_sticky)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] id, input logic [15:0] amt);
    in_valid     = v;
    in_client_id = id;
    in_amount    = amt;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(1'b0, 5'd0, 16'd0);
    out_ready = 1'b0;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (client_id !== 5'd0) $display("FAIL reset_id: got %0d want 0", client_id); else pass_cnt++;
    total_cnt++; if (amount !== 16'd0) $display("FAIL reset_amount: got %0h want 0", amount); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (overflow_sticky !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow_sticky); else pass_cnt++;
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 5'd3, 16'd10);
    step();
    drive(1'b0, 5'd0, 16'd0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_latency: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd1) $display("FAIL single_count1: got %0d want 1", fifo_count); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (client_id !== 5'd3) $display("FAIL single_id: got %0d want 3", client_id); else pass_cnt++;
    total_cnt++; if (amount !== 16'd10) $display("FAIL single_amount: got %0d want 10", amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drop: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (amount !== 16'd0) $display("FAIL single_idle_amount: got %0d want 0", amount); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd0) $display("FAIL single_count0: got %0d want 0", fifo_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 5'd1, 16'd5);
    step();
    drive(1'b1, 5'd2, 16'd5);
    step();
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd1) $display("FAIL b2b_first: got v=%0b id=%0d want v=1 id=1", out_valid, client_id); else pass_cnt++;
    drive(1'b1, 5'd3, 16'd5);
    step();
    drive(1'b0, 5'd0, 16'd0);
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd2) $display("FAIL b2b_second: got v=%0b id=%0d want v=1 id=2", out_valid, client_id); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd3 || amount !== 16'd5) $display("FAIL b2b_third: got v=%0b id=%0d amt=%0d want v=1 id=3 amt=5", out_valid, client_id, amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_end: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_gap();
    out_ready = 1'b1;
    drive(1'b1, 5'd7, 16'd4);
    step();
    drive(1'b1, 5'd7, 16'd4);
    step();
    drive(1'b0, 5'd0, 16'd0);
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd7 || amount !== 16'd4) $display("FAIL gap_first: got v=%0b id=%0d amt=%0d want v=1 id=7 amt=4", out_valid, client_id, amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || amount !== 16'd0) $display("FAIL gap_idle1: got v=%0b amt=%0d want v=0 amt=0", out_valid, amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || amount !== 16'd0) $display("FAIL gap_idle2: got v=%0b amt=%0d want v=0 amt=0", out_valid, amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd7 || amount !== 16'd4) $display("FAIL gap_second: got v=%0b id=%0d amt=%0d want v=1 id=7 amt=4", out_valid, client_id, amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL gap_end: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_coalesce();
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 16'h0011);
    step();
    drive(1'b1, 5'd4, 16'hFFF0);
    step();
    drive(1'b1, 5'd4, 16'h0020);
    step();
    drive(1'b0, 5'd0, 16'd0);
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd1) $display("FAIL merge_presented: got v=%0b id=%0d want v=1 id=1", out_valid, client_id); else pass_cnt++;
`ifdef CXL_FEEDER_COALESCE_EN
    total_cnt++; if (fifo_count !== 4'd1) $display("FAIL merge_count: got %0d want 1", fifo_count); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (client_id !== 5'd4 || amount !== 16'hFFFF) $display("FAIL merge_sat: got id=%0d amt=%0h want id=4 amt=ffff", client_id, amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL merge_end: got %0b want 0", out_valid); else pass_cnt++;
`else
    total_cnt++; if (fifo_count !== 4'd2) $display("FAIL nomerge_count: got %0d want 2", fifo_count); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (client_id !== 5'd4 || amount !== 16'hFFF0) $display("FAIL nomerge_first: got id=%0d amt=%0h want id=4 amt=fff0", client_id, amount); else pass_cnt++;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL nomerge_gap: got %0b want 0", out_valid); else pass_cnt++;
    step();
    total_cnt++; if (client_id !== 5'd4 || amount !== 16'h0020) $display("FAIL nomerge_second: got id=%0d amt=%0h want id=4 amt=20", client_id, amount); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL nomerge_end: got %0b want 0", out_valid); else pass_cnt++;
`endif
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 10; k <= 18; k++) begin
      drive(1'b1, 5'(k), 16'h0100 + 16'(k));
      step();
    end
    drive(1'b0, 5'd0, 16'd0);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL ovf_in_ready: got %0b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", fifo_count); else pass_cnt++;
    total_cnt++; if (overflow_sticky !== 1'b0) $display("FAIL ovf_early: got %0b want 0", overflow_sticky); else pass_cnt++;
    drive(1'b1, 5'd19, 16'h0113);
    step();
    drive(1'b0, 5'd0, 16'd0);
    total_cnt++; if (overflow_sticky !== 1'b1) $display("FAIL ovf_set: got %0b want 1", overflow_sticky); else pass_cnt++;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd10 || amount !== 16'h010A) $display("FAIL ovf_hold: got v=%0b id=%0d amt=%0h want v=1 id=10 amt=10a", out_valid, client_id, amount); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd8) $display("FAIL ovf_count_hold: got %0d want 8", fifo_count); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 11; k <= 18; k++) begin
      step();
      total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'(k) || amount !== 16'h0100 + 16'(k)) $display("FAIL ovf_drain_%0d: got v=%0b id=%0d amt=%0h want v=1 id=%0d amt=%0h", k, out_valid, client_id, amount, k, 16'h0100 + 16'(k)); else pass_cnt++;
    end
    step();
    total_cnt++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) $display("FAIL ovf_drained: got v=%0b cnt=%0d want v=0 cnt=0", out_valid, fifo_count); else pass_cnt++;
    total_cnt++; if (overflow_sticky !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflow_sticky); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 20; k <= 23; k++) begin
      drive(1'b1, 5'(k), 16'(k));
      step();
    end
    drive(1'b0, 5'd0, 16'd0);
    total_cnt++; if (out_valid !== 1'b1 || client_id !== 5'd20 || fifo_count !== 4'd3) $display("FAIL mid_setup: got v=%0b id=%0d cnt=%0d want v=1 id=20 cnt=3", out_valid, client_id, fifo_count); else pass_cnt++;
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    total_cnt++; if (out_valid !== 1'b0 || fifo_count !== 4'd0 || overflow_sticky !== 1'b0) $display("FAIL mid_reset: got v=%0b cnt=%0d ovf=%0b want 0 0 0", out_valid, fifo_count, overflow_sticky); else pass_cnt++;
    total_cnt++; if (client_id !== 5'd0 || amount !== 16'd0) $display("FAIL mid_reset_out: got id=%0d amt=%0d want 0 0", client_id, amount); else pass_cnt++;
    out_ready = 1'b1;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) $display("FAIL mid_discard: got v=%0b cnt=%0d want v=0 cnt=0", out_valid, fifo_count); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_coalesce();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cxl_order_feeder.md
Name: cxl_order_feeder

Overview:
- Upstream stage of the downstream cancel-order accumulator: buffers incoming cancel requests (client_id, amount) and presents them one at a time on the accumulator's client_id/amount inputs.
- Enforces a configurable gap between back-to-back requests for the same client, so the accumulator's read-modify-write of cancelled_orders completes before the next update to that address.
- Drives amount=0 when idle, so the accumulator sees a harmless add.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- GAP_CYCLES, 2, idle cycles inserted between consecutive issues to the same client_id; 0 disables the gap.
- CLIENT_W, 5, client id width.
- AMOUNT_W, 16, amount width.

Ports:
- clk  in  1  clock; all logic on posedge.
- HRESETn  in  1  reset; synchronous, active-low.
- in_valid  in  1  request offered.
- in_client_id  in  CLIENT_W  client of offered request.
- in_amount  in  AMOUNT_W  cancelled amount of offered request.
- in_ready  out  1  feeder accepts a request this cycle.
- out_ready  in  1  downstream accepts the presented request.
- out_valid  out  1  client_id/amount carry a real request.
- client_id  out  CLIENT_W  presented client (to accumulator).
- amount  out  AMOUNT_W  presented amount (to accumulator).
- fifo_count  out  $clog2(DEPTH)+1  entries held, excluding the presented one.
- overflow_sticky  out  1  set when in_valid arrives while in_ready=0.

Behaviour:
- Reset (HRESETn=0 at posedge): FIFO flushed, fifo_count=0, state IDLE, out_valid=0, client_id=0, amount=0, in_ready=1, overflow_sticky=0, gap counter=0, last_id=0. Reset mid-transfer discards the presented and all queued requests.
- Push: on in_valid && in_ready. in_ready = (fifo_count != DEPTH), registered-state based, with no same-cycle pass-through when full.
- Overflow: in_valid && !in_ready sets overflow_sticky; the request is dropped; only reset clears the flag.
- Outputs are registered. client_id/amount are held stable while out_valid && !out_ready. With out_valid=0, client_id=0 and amount=0.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE -> ISSUE when fifo_count>0. The head is popped into the output register; out_valid=1 the next cycle, so latency from push into an empty feeder to out_valid is 2 cycles.
  - ISSUE: a transfer occurs when out_ready=1; last_id <= client_id. Then:
    - FIFO empty: -> IDLE.
    - Head client_id == last_id and GAP_CYCLES>0: -> GAP, counter=GAP_CYCLES.
    - Otherwise: pop head and stay in ISSUE (back-to-back, one per cycle).
  - GAP: out_valid=0, amount=0. The counter decrements each cycle; at 1, pop head and go -> ISSUE. The gap length is fixed once entered and is not re-evaluated.
- Simultaneous push and pop: fifo_count unchanged; a push into a full FIFO is not allowed even if a pop occurs the same cycle.
- Pointers wrap modulo DEPTH. Amounts pass through unmodified.

Optional Feature:
- Macro: CXL_FEEDER_COALESCE_EN.
- With the macro: a push whose in_client_id equals the tail entry's client_id is merged into the tail. The tail amount becomes the saturating sum (clamped at 2^AMOUNT_W-1); fifo_count does not change.
  - Merge applies only when fifo_count>=1; the presented output-register entry is never merged into.
  - A merge is accepted even when full, so in_ready = !full || (tail_id==in_client_id && fifo_count>0).
- Without the macro: every accepted push occupies a new entry; no comparison logic is synthesised.

Decomposition:
- Package cxl_pkg:
  - Constants CLIENT_W=5, AMOUNT_W=16.
  - typedef struct packed cxl_req_t {client_id, amount}.
  - typedef enum feeder_state_t {IDLE, ISSUE, GAP}.
- One sub-module, cxl_req_fifo: synchronous FIFO of cxl_req_t with push, pop, count, head and tail read. It exposes tail write-back for coalescing.
- cxl_order_feeder holds the FSM, output register, gap counter and overflow flag.

Test Plan:
- Reset then single push (id=3, amt=10), out_ready=1 -> out_valid high 2 cycles after push with client_id=3, amount=10, for exactly one cycle; then amount=0, fifo_count=0.
- Push ids 1,2,3 back-to-back (amt 5 each), out_ready=1, GAP_CYCLES=2 -> three consecutive issue cycles, no gap.
- Push id=7 amt=4 twice, macro off -> issue, 2 cycles out_valid=0, then the second issue; both show amount=4.
- Hold out_ready=0, push 9 distinct ids with DEPTH=8 -> 8 queued plus 1 presented. in_ready=0 and fifo_count=8; a tenth push sets overflow_sticky; the held output stays stable.
- Macro on: push id=4 amt=0xFFF0 then id=4 amt=0x20 while out_ready=0 with a different id presented -> one queued entry with amount=0xFFFF.
- Assert HRESETn=0 for one cycle while in ISSUE with 3 queued -> next cycle out_valid=0, fifo_count=0, overflow_sticky=0.
